// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the set-associative cache controller:
// FSM state encoding and address-field width helpers.
package cache_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REFILL = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_WDONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        REFILL = ST_REFILL,
        WRITE  = ST_WRITE,
        WDONE  = ST_WDONE
    } state_t;

    function automatic int off_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int aw, input int sets, input int words);
        return aw - $clog2(sets) - $clog2(words);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid/tag/data storage with combinational lookup,
// synchronous word write, line fill and synchronous valid clear.
module cache_way_array
    import cache_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 5,
    parameter int SETS       = 8,
    parameter int WORDS      = 4,
    parameter int IDX_W      = idx_w(SETS),
    parameter int OFF_W      = off_w(WORDS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    input  logic [OFF_W-1:0]      rd_off_i,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [OFF_W-1:0]      wr_off_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  fill_i,
    input  logic [TAG_W-1:0]      fill_tag_i,
    output logic                  valid_o,
    output logic [TAG_W-1:0]      tag_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic                  valid_q [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WORDS];

    assign valid_o = valid_q[rd_idx_i];
    assign tag_o   = tag_q[rd_idx_i];
    assign data_o  = data_q[rd_idx_i][rd_off_i];

    // Valid bits: cleared by reset, set when a line finishes filling.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
        end else if (fill_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag is written together with the final refill word.
    always_ff @(posedge clk_i) begin
        if (fill_i) tag_q[wr_idx_i] <= fill_tag_i;
    end

    // Word write for refill data or a store hit.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// N-way set-associative write-through, no-write-allocate data cache controller.
// Optional hit/miss counters enabled by defining CACHE_STATS_EN.
module set_assoc_cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int WAYS            = 2,
    parameter int SETS            = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemReadCpu,
    input  logic                  MemWriteCpu,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Stall,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemWData,
    input  logic [DATA_WIDTH-1:0] MemRData,
`ifdef CACHE_STATS_EN
    output logic [31:0]           HitCount,
    output logic [31:0]           MissCount,
`endif
    input  logic                  MemReady
);

    localparam int OFF = off_w(WORDS_PER_BLOCK);
    localparam int IDX = idx_w(SETS);
    localparam int TAG = tag_w(ADDR_WIDTH, SETS, WORDS_PER_BLOCK);
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic [TAG-1:0] a_tag;
    logic [IDX-1:0] a_idx;
    logic [OFF-1:0] a_off;
    assign {a_tag, a_idx, a_off} = Address;

    logic                  w_valid [WAYS];
    logic [TAG-1:0]        w_tag   [WAYS];
    logic [DATA_WIDTH-1:0] w_data  [WAYS];
    logic [WAYS-1:0]       hit_vec;
    logic                  hit;
    logic [WW-1:0]         hit_way;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [WW-1:0]         victim;

    state_t         state_q, state_d;
    logic [WW-1:0]  vway_q, vway_d;
    logic [TAG-1:0] vtag_q, vtag_d;
    logic [IDX-1:0] vidx_q, vidx_d;
    logic [OFF-1:0] cnt_q, cnt_d;
    logic [WW-1:0]  rr_q [SETS];
    logic [WW-1:0]  rr_next;

    logic                  wr_en;
    logic [WW-1:0]         wr_way;
    logic [IDX-1:0]        wr_idx;
    logic [OFF-1:0]        wr_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  fill;
    logic                  rr_adv;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way_array #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_W      (TAG),
            .SETS       (SETS),
            .WORDS      (WORDS_PER_BLOCK),
            .IDX_W      (IDX),
            .OFF_W      (OFF)
        ) u_way (
            .clk_i      (CLK),
            .rst_i      (RST),
            .rd_idx_i   (a_idx),
            .rd_off_i   (a_off),
            .wr_en_i    (wr_en && (wr_way == WW'(w))),
            .wr_idx_i   (wr_idx),
            .wr_off_i   (wr_off),
            .wr_data_i  (wr_data),
            .fill_i     (fill && (wr_way == WW'(w))),
            .fill_tag_i (vtag_q),
            .valid_o    (w_valid[w]),
            .tag_o      (w_tag[w]),
            .data_o     (w_data[w])
        );
        assign hit_vec[w] = w_valid[w] && (w_tag[w] == a_tag);
    end

    assign hit = |hit_vec;

    // Select the hitting way's word (at most one way can hit).
    always_comb begin
        hit_way  = '0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_way  = WW'(w);
                hit_data = w_data[w];
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's pointer.
    always_comb begin
        victim = rr_q[a_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_valid[w]) victim = WW'(w);
        end
    end

    assign rr_next = (rr_q[vidx_q] == WW'(WAYS - 1)) ? '0
                                                     : rr_q[vidx_q] + 1'b1;

    // Next-state and output decode for the controller FSM.
    always_comb begin
        state_d    = state_q;
        vway_d     = vway_q;
        vtag_d     = vtag_q;
        vidx_d     = vidx_q;
        cnt_d      = cnt_q;
        Stall      = 1'b0;
        DataOut    = '0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemAddress = '0;
        MemWData   = '0;
        wr_en      = 1'b0;
        wr_way     = vway_q;
        wr_idx     = vidx_q;
        wr_off     = cnt_q;
        wr_data    = MemRData;
        fill       = 1'b0;
        rr_adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (MemWriteCpu) begin
                    Stall   = 1'b1;
                    state_d = WRITE;
                end else if (MemReadCpu) begin
                    if (hit) begin
                        DataOut = hit_data;
                    end else begin
                        Stall   = 1'b1;
                        state_d = REFILL;
                        vway_d  = victim;
                        vtag_d  = a_tag;
                        vidx_d  = a_idx;
                        cnt_d   = '0;
                    end
                end
            end
            REFILL: begin
                Stall      = 1'b1;
                MemRead    = 1'b1;
                MemAddress = {vtag_q, vidx_q, cnt_q};
                if (MemReady) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF'(WORDS_PER_BLOCK - 1)) begin
                        fill    = 1'b1;
                        rr_adv  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                Stall      = 1'b1;
                MemWrite   = 1'b1;
                MemAddress = Address;
                MemWData   = DataIn;
                if (MemReady) begin
                    state_d = WDONE;
                    if (hit) begin
                        wr_en   = 1'b1;
                        wr_way  = hit_way;
                        wr_idx  = a_idx;
                        wr_off  = a_off;
                        wr_data = DataIn;
                    end
                end
            end
            WDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and refill-context registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            vway_q  <= '0;
            vtag_q  <= '0;
            vidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vway_q  <= vway_d;
            vtag_q  <= vtag_d;
            vidx_q  <= vidx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Round-robin pointers advance once per completed refill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (rr_adv) begin
            rr_q[vidx_q] <= rr_next;
        end
    end

`ifdef CACHE_STATS_EN
    logic        rd_evt;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    assign rd_evt = (state_q == IDLE) && MemReadCpu && !MemWriteCpu;

    // Saturating read hit/miss counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_evt && hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (rd_evt && !hit && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule
